// File: rtl/histogram_cdf_uretici.sv
// Frame histogram accumulator with in-place prefix-sum (CDF) and single-cycle CDF query port.
// Optional macro HISTOGRAM_OTOMATIK_CERCEVE_EN: leave SUN automatically after M*N queries.
module histogram_cdf_uretici #(
   parameter int M = 320,
   parameter int N = 240
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        pixel_gecerli_i,
   input  logic [7:0]  pixel_i,
   input  logic        sorgu_gecerli_i,
   input  logic [7:0]  sorgu_pixel_i,
   input  logic        yeni_cerceve_i,
   output logic        hazir_o,
   output logic        cdf_hazir_o,
   output logic        etkin_o,
   output logic [7:0]  pixel_o,
   output logic [16:0] cdf_o,
   output logic [16:0] cdf_min_o
);

   localparam logic [16:0] MN = 17'(M * N);

   typedef enum logic [1:0] {TEMIZLE, TOPLA, CDF, SUN} durum_t;
   durum_t r_durum, w_durum_next;

   logic [16:0] r_bin [0:255];
   logic [16:0] r_rd_data;
   logic [7:0]  w_rd_addr;
   logic [7:0]  w_wr_addr;
   logic [16:0] w_wr_data;
   logic        w_we;

   logic [7:0]  r_clr_idx;
   logic [16:0] r_kabul_cnt;
   logic        r_s1_valid;
   logic [7:0]  r_s1_addr;
   logic        r_s2_valid;
   logic [7:0]  r_s2_addr;
   logic [16:0] r_s2_data;
   logic [8:0]  r_cdf_idx;
   logic [16:0] r_sum;
   logic        r_min_bulundu;
   logic [16:0] r_cdf_min;
   logic        r_etkin;
   logic [7:0]  r_pixel_o;
   logic [16:0] r_cdf_hold;

   logic        w_kabul;
   logic        w_sorgu;
   logic [16:0] w_inc;
   logic [16:0] w_cdf_sum;
   logic        w_cdf_wr;
   logic        w_oto_cikis;

   assign hazir_o     = (r_durum == TOPLA) && (r_kabul_cnt != MN);
   assign cdf_hazir_o = (r_durum == SUN);
   assign w_kabul     = pixel_gecerli_i && hazir_o;
   assign w_sorgu     = sorgu_gecerli_i && (r_durum == SUN);

   // Previous cycle's write is not yet visible in r_rd_data, so forward it on an address match.
   assign w_inc     = ((r_s2_valid && (r_s2_addr == r_s1_addr)) ? r_s2_data : r_rd_data) + 17'd1;
   assign w_cdf_sum = r_sum + r_rd_data;
   assign w_cdf_wr  = (r_durum == CDF) && (r_cdf_idx != 9'd0);

`ifdef HISTOGRAM_OTOMATIK_CERCEVE_EN
   logic [16:0] r_sorgu_cnt;
   assign w_oto_cikis = w_sorgu && (r_sorgu_cnt == MN - 17'd1);

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_sorgu_cnt <= '0;
      end else if (r_durum != SUN || w_oto_cikis) begin
         r_sorgu_cnt <= '0;
      end else if (w_sorgu) begin
         r_sorgu_cnt <= r_sorgu_cnt + 17'd1;
      end
   end
`else
   assign w_oto_cikis = 1'b0;
`endif

   always_comb begin
      w_durum_next = r_durum;
      case (r_durum)
         TEMIZLE: if (r_clr_idx == 8'd255) w_durum_next = TOPLA;
         TOPLA:   if (r_kabul_cnt == MN && !r_s1_valid) w_durum_next = CDF;
         CDF:     if (r_cdf_idx == 9'd256) w_durum_next = SUN;
         SUN:     if (yeni_cerceve_i || w_oto_cikis) w_durum_next = TEMIZLE;
         default: w_durum_next = TEMIZLE;
      endcase
   end

   always_comb begin
      w_we      = 1'b0;
      w_wr_addr = 8'd0;
      w_wr_data = 17'd0;
      w_rd_addr = 8'd0;
      case (r_durum)
         TEMIZLE: begin
            w_we      = 1'b1;
            w_wr_addr = r_clr_idx;
         end
         TOPLA: begin
            w_we      = r_s1_valid;
            w_wr_addr = r_s1_addr;
            w_wr_data = w_inc;
            w_rd_addr = pixel_i;
         end
         CDF: begin
            // Read bin k while writing the running sum into bin k-1.
            w_we      = w_cdf_wr;
            w_wr_addr = 8'(r_cdf_idx - 9'd1);
            w_wr_data = w_cdf_sum;
            w_rd_addr = r_cdf_idx[7:0];
         end
         SUN:     w_rd_addr = sorgu_pixel_i;
         default: w_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_we) r_bin[w_wr_addr] <= w_wr_data;
      r_rd_data <= r_bin[w_rd_addr];
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         r_durum       <= TEMIZLE;
         r_clr_idx     <= '0;
         r_kabul_cnt   <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_addr     <= '0;
         r_s2_valid    <= 1'b0;
         r_s2_addr     <= '0;
         r_s2_data     <= '0;
         r_cdf_idx     <= '0;
         r_sum         <= '0;
         r_min_bulundu <= 1'b0;
         r_cdf_min     <= '0;
         r_etkin       <= 1'b0;
         r_pixel_o     <= '0;
         r_cdf_hold    <= '0;
      end else begin
         r_durum    <= w_durum_next;
         r_clr_idx  <= (r_durum == TEMIZLE) ? r_clr_idx + 8'd1 : 8'd0;
         r_s1_valid <= w_kabul;
         if (w_kabul) r_s1_addr <= pixel_i;
         r_s2_valid <= r_s1_valid;
         r_s2_addr  <= r_s1_addr;
         r_s2_data  <= w_inc;

         if (r_durum == TEMIZLE)  r_kabul_cnt <= '0;
         else if (w_kabul)        r_kabul_cnt <= r_kabul_cnt + 17'd1;

         if (r_durum == CDF) begin
            r_cdf_idx <= r_cdf_idx + 9'd1;
            if (w_cdf_wr) begin
               r_sum <= w_cdf_sum;
               if (!r_min_bulundu && w_cdf_sum != 17'd0) begin
                  r_cdf_min     <= w_cdf_sum;
                  r_min_bulundu <= 1'b1;
               end
            end
         end else begin
            r_cdf_idx     <= '0;
            r_sum         <= '0;
            r_min_bulundu <= 1'b0;
         end

         r_etkin <= w_sorgu;
         if (w_sorgu) r_pixel_o  <= sorgu_pixel_i;
         if (r_etkin) r_cdf_hold <= r_rd_data;
      end
   end

   assign etkin_o   = r_etkin;
   assign pixel_o   = r_pixel_o;
   assign cdf_o     = r_etkin ? r_rd_data : r_cdf_hold;
   assign cdf_min_o = r_cdf_min;

endmodule

// File: tb/tb_histogram_cdf_uretici.sv
// Directed bench for histogram_cdf_uretici with a 4x2 frame and hand-computed CDF values.
module tb_histogram_cdf_uretici;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        pixel_gecerli_i = 1'b0;
   logic [7:0]  pixel_i = '0;
   logic        sorgu_gecerli_i = 1'b0;
   logic [7:0]  sorgu_pixel_i = '0;
   logic        yeni_cerceve_i = 1'b0;
   logic        hazir_o, cdf_hazir_o, etkin_o;
   logic [7:0]  pixel_o;
   logic [16:0] cdf_o, cdf_min_o;

   int n_cmp = 0;
   int n_err = 0;

   histogram_cdf_uretici #(.M(4), .N(2)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .pixel_gecerli_i(pixel_gecerli_i), .pixel_i(pixel_i),
      .sorgu_gecerli_i(sorgu_gecerli_i), .sorgu_pixel_i(sorgu_pixel_i),
      .yeni_cerceve_i(yeni_cerceve_i),
      .hazir_o(hazir_o), .cdf_hazir_o(cdf_hazir_o), .etkin_o(etkin_o),
      .pixel_o(pixel_o), .cdf_o(cdf_o), .cdf_min_o(cdf_min_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_hazir(output int n);
      n = 0;
      while (!hazir_o && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_cdf(output int n);
      n = 0;
      while (!cdf_hazir_o && n < 400) begin
         tick();
         n++;
      end
   endtask

   task automatic send_pixel(input logic [7:0] p);
      pixel_gecerli_i = 1'b1;
      pixel_i         = p;
      tick();
      pixel_gecerli_i = 1'b0;
      $display("pixel %0d sent", p);
   endtask

   task automatic query(input string tag, input logic [7:0] p, input logic [16:0] e, input logic [16:0] emin);
      sorgu_gecerli_i = 1'b1;
      sorgu_pixel_i   = p;
      tick();
      sorgu_gecerli_i = 1'b0;
      $display("query %0d -> etkin %0d cdf %0d cdf_min %0d", p, etkin_o, cdf_o, cdf_min_o);
      check({tag, "_etkin"}, 32'(etkin_o), 32'd1);
      check({tag, "_pixel"}, 32'(pixel_o), 32'(p));
      check({tag, "_cdf"}, 32'(cdf_o), 32'(e));
      check({tag, "_min"}, 32'(cdf_min_o), 32'(emin));
   endtask

   initial begin
      int n;
      logic [7:0]  pb [8] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd5, 8'd5, 8'd5, 8'd7};
      logic [16:0] tbl [10] = '{17'd0, 17'd0, 17'd0, 17'd4, 17'd4, 17'd7, 17'd7, 17'd8, 17'd8, 17'd8};

      // Reset state
      tick();
      tick();
      check("rst_hazir", 32'(hazir_o), 32'd0);
      check("rst_cdf_hazir", 32'(cdf_hazir_o), 32'd0);
      check("rst_etkin", 32'(etkin_o), 32'd0);
      check("rst_pixel", 32'(pixel_o), 32'd0);
      check("rst_cdf", 32'(cdf_o), 32'd0);
      check("rst_min", 32'(cdf_min_o), 32'd0);
      rstn_i = 1'b1;
      wait_hazir(n);
      check("clear_len", 32'(n), 32'd256);

      // Frame A: eight pixels of 100
      for (int i = 0; i < 8; i++) send_pixel(8'd100);
      check("a_hazir_drop", 32'(hazir_o), 32'd0);
      wait_cdf(n);
      check("a_cdf_latency_ok", 32'(n <= 262), 32'd1);
      query("a_q100", 8'd100, 17'd8, 17'd8);
      query("a_q99", 8'd99, 17'd0, 17'd8);
      tick();
      check("a_idle_etkin", 32'(etkin_o), 32'd0);
      check("a_idle_cdf_hold", 32'(cdf_o), 32'd0);
      check("a_idle_pixel_hold", 32'(pixel_o), 32'd99);
      pixel_gecerli_i = 1'b1;
      pixel_i         = 8'd9;
      for (int i = 0; i < 3; i++) tick();
      pixel_gecerli_i = 1'b0;
      query("a_q9_unchanged", 8'd9, 17'd0, 17'd8);
      sorgu_gecerli_i = 1'b1;
      sorgu_pixel_i   = 8'd100;
      yeni_cerceve_i  = 1'b1;
      tick();
      sorgu_gecerli_i = 1'b0;
      yeni_cerceve_i  = 1'b0;
      $display("query 100 with new frame -> etkin %0d cdf %0d", etkin_o, cdf_o);
      check("a_yeni_etkin", 32'(etkin_o), 32'd1);
      check("a_yeni_cdf", 32'(cdf_o), 32'd8);
      check("a_yeni_exit", 32'(cdf_hazir_o), 32'd0);

      // Frame B: queries during TOPLA are ignored, then mixed values back-to-back
      wait_hazir(n);
      check("b_clear_len", 32'(n), 32'd256);
      sorgu_gecerli_i = 1'b1;
      sorgu_pixel_i   = 8'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("b_topla_query_ignored", 32'(etkin_o), 32'd0);
      end
      sorgu_gecerli_i = 1'b0;
      pixel_gecerli_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pixel_i = pb[i];
         tick();
      end
      pixel_gecerli_i = 1'b0;
      wait_cdf(n);
      check("b_cdf_latency_ok", 32'(n <= 262), 32'd1);
      query("b_q2", 8'd2, 17'd0, 17'd4);
      query("b_q3", 8'd3, 17'd4, 17'd4);
      query("b_q6", 8'd6, 17'd7, 17'd4);
      query("b_q7", 8'd7, 17'd8, 17'd4);
      query("b_q0", 8'd0, 17'd0, 17'd4);
      query("b_q1", 8'd1, 17'd0, 17'd4);
      query("b_q4", 8'd4, 17'd4, 17'd4);
      query("b_q5", 8'd5, 17'd7, 17'd4);
`ifdef HISTOGRAM_OTOMATIK_CERCEVE_EN
      check("b_auto_exit", 32'(cdf_hazir_o), 32'd0);
`else
      check("b_no_auto_exit", 32'(cdf_hazir_o), 32'd1);
      sorgu_gecerli_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sorgu_pixel_i = 8'(i);
         tick();
         check("b_burst_etkin", 32'(etkin_o), 32'd1);
         check("b_burst_cdf", 32'(cdf_o), 32'(tbl[i]));
      end
      sorgu_gecerli_i = 1'b0;
      tick();
      check("b_burst_end_etkin", 32'(etkin_o), 32'd0);
      check("b_burst_cdf_hold", 32'(cdf_o), 32'd8);
      yeni_cerceve_i = 1'b1;
      tick();
      yeni_cerceve_i = 1'b0;
      check("b_yeni_exit", 32'(cdf_hazir_o), 32'd0);
`endif

      // Frame C: reset mid-accumulation, then eight pixels of 0
      wait_hazir(n);
      for (int i = 0; i < 5; i++) send_pixel(8'd200);
      rstn_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      check("c_rst_hazir", 32'(hazir_o), 32'd0);
      check("c_rst_min", 32'(cdf_min_o), 32'd0);
      wait_hazir(n);
      check("c_clear_len", 32'(n), 32'd256);
      for (int i = 0; i < 8; i++) send_pixel(8'd0);
      wait_cdf(n);
      check("c_cdf_latency_ok", 32'(n <= 262), 32'd1);
      query("c_q0", 8'd0, 17'd8, 17'd8);
      query("c_q200", 8'd200, 17'd8, 17'd8);
      sorgu_gecerli_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sorgu_pixel_i = 8'(20 + i);
         tick();
         check("c_burst_etkin", 32'(etkin_o), 32'd1);
         check("c_burst_pixel", 32'(pixel_o), 32'(20 + i));
      end
      sorgu_gecerli_i = 1'b0;
      tick();
      check("c_burst_end_etkin", 32'(etkin_o), 32'd0);
      check("c_pixel_hold", 32'(pixel_o), 32'd25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
